// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit registered ALU: the opcode encoding,
// the datapath width and a few width-matched constants.
package alu_pkg;

  // Datapath width. The opcode field is 4 bits wide independently of this.
  localparam int DATA_W = 4;
  localparam int CTL_W  = 4;

  // Width-matched constants so that the arithmetic stays lint-clean.
  localparam logic [DATA_W-1:0] DATA_ZERO = '0;
  localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1);

  // Opcode encoding. Codes 14 and 15 are unassigned and decode as "illegal",
  // which returns a zero result with no carry.
  typedef enum logic [CTL_W-1:0] {
    SEL      = 4'd0,
    INC      = 4'd1,
    DEC      = 4'd2,
    ADD      = 4'd3,
    ADD_c    = 4'd4,
    SUB      = 4'd5,
    SUB_b    = 4'd6,
    AND      = 4'd7,
    OR       = 4'd8,
    XOR      = 4'd9,
    SHIFT_L  = 4'd10,
    SHIFT_R  = 4'd11,
    ROTATE_L = 4'd12,
    ROTATE_R = 4'd13
  } opcode_e;

  // Result of one ALU evaluation, before it is registered.
  typedef struct packed {
    logic              cout;
    logic [DATA_W-1:0] res;
  } op_result_t;

  // True when the opcode field carries an assigned operation.
  function automatic logic is_legal_op(input logic [CTL_W-1:0] ctl);
    return (ctl <= CTL_W'(ROTATE_R));
  endfunction

endpackage : alu_pkg

// File: rtl/alu_ops.sv
// Purely combinational ALU core: evaluates one opcode on (a, b, cin) and
// produces a wrap-around result plus carry-out / borrow-out.
module alu_ops
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  logic [CTL_W-1:0]  ctl,
  output logic [DATA_W-1:0] res,
  output logic              cout
);

  // One extra bit on every adder/subtractor: the top bit is the carry for
  // additions and the borrow for subtractions (it goes to 1 exactly when the
  // unsigned difference underflows, i.e. a < b + cin).
  logic [DATA_W:0] add_sum;
  logic [DATA_W:0] add_c_sum;
  logic [DATA_W:0] sub_diff;
  logic [DATA_W:0] sub_b_diff;
  logic [DATA_W:0] cin_ext;

  assign cin_ext    = {{DATA_W{1'b0}}, cin};
  assign add_sum    = {1'b0, a} + {1'b0, b};
  assign add_c_sum  = add_sum + cin_ext;
  assign sub_diff   = {1'b0, a} - {1'b0, b};
  assign sub_b_diff = sub_diff - cin_ext;

  // Opcode decode; cin only matters for ADD_c and SUB_b, and every opcode
  // other than the four add/subtract forms reports carry 0.
  always_comb begin
    res  = DATA_ZERO;
    cout = 1'b0;
    case (ctl)
      SEL:      res = b;
      INC:      res = b + DATA_ONE;
      DEC:      res = b - DATA_ONE;
      ADD: begin
        res  = add_sum[DATA_W-1:0];
        cout = add_sum[DATA_W];
      end
      ADD_c: begin
        res  = add_c_sum[DATA_W-1:0];
        cout = add_c_sum[DATA_W];
      end
      SUB: begin
        res  = sub_diff[DATA_W-1:0];
        cout = sub_diff[DATA_W];
      end
      SUB_b: begin
        res  = sub_b_diff[DATA_W-1:0];
        cout = sub_b_diff[DATA_W];
      end
      AND:      res = a & b;
      OR:       res = a | b;
      XOR:      res = a ^ b;
      SHIFT_L:  res = {a[DATA_W-2:0], 1'b0};
      SHIFT_R:  res = {1'b0, a[DATA_W-1:1]};
      ROTATE_L: res = {a[DATA_W-2:0], a[DATA_W-1]};
      ROTATE_R: res = {a[0], a[DATA_W-1:1]};
      default: begin
        res  = DATA_ZERO;
        cout = 1'b0;
      end
    endcase
  end

endmodule : alu_ops

// File: rtl/alu_unit.sv
// 4-bit registered ALU. One operation is accepted on every cycle that
// valid_in is high; its result, carry and zero flag appear one cycle later
// together with valid_out.
//
// Handshake: valid_in qualifies a, b, cin and ctl in the cycle it is high.
// There is no ready: every valid cycle is accepted, back-to-back included.
// valid_out is high for exactly the cycle after an accepted operation; on
// other cycles alu/carry/zero keep the last result.
module alu_unit
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  logic [CTL_W-1:0]  ctl,
  output logic              valid_out,
  output logic [DATA_W-1:0] alu,
  output logic              carry,
  output logic              zero
);

  op_result_t op_out;

  alu_ops u_alu_ops (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .ctl  (ctl),
    .res  (op_out.res),
    .cout (op_out.cout)
  );

  // zero is derived from the result being loaded, so it changes in the same
  // cycle as alu and the relation zero == (alu == 0) always holds.
  logic next_zero;
  assign next_zero = (op_out.res == DATA_ZERO);

  // Output registers: reset beats valid_in; idle cycles hold the last result.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu       <= DATA_ZERO;
      carry     <= 1'b0;
      zero      <= 1'b1;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        alu   <= op_out.res;
        carry <= op_out.cout;
        zero  <= next_zero;
      end
    end
  end

endmodule : alu_unit

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: directed scenarios push literal expected values,
// the random run pushes values from an independent integer model.
// Expected word layout: {valid_out, carry, zero, alu}.
module tb_alu_unit;
  import alu_pkg::*;

  localparam int W = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] ctl;
  logic       valid_out;
  logic [3:0] alu;
  logic       carry;
  logic       zero;

  logic [W-1:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  // Model state mirrors the architectural output registers.
  logic       m_valid = 1'b0;
  logic       m_carry = 1'b0;
  logic       m_zero  = 1'b1;
  logic [3:0] m_alu   = 4'h0;

  alu_unit dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .ctl       (ctl),
    .valid_out (valid_out),
    .alu       (alu),
    .carry     (carry),
    .zero      (zero)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  // Integer arithmetic, low four bits kept; carry from range checks.
  function automatic logic [4:0] model_op(input logic [3:0] ma, input logic [3:0] mb,
                                          input logic mc, input logic [3:0] mctl);
    int ai;
    int bi;
    int ci;
    int r;
    logic c;
    ai = int'(ma);
    bi = int'(mb);
    ci = int'(mc);
    r  = 0;
    c  = 1'b0;
    case (mctl)
      4'd0:  r = bi;
      4'd1:  r = bi + 1;
      4'd2:  r = bi - 1;
      4'd3:  begin r = ai + bi;      c = (r > 15); end
      4'd4:  begin r = ai + bi + ci; c = (r > 15); end
      4'd5:  begin r = ai - bi;      c = (r < 0);  end
      4'd6:  begin r = ai - bi - ci; c = (r < 0);  end
      4'd7:  r = int'(ma & mb);
      4'd8:  r = int'(ma | mb);
      4'd9:  r = int'(ma ^ mb);
      4'd10: r = ai * 2;
      4'd11: r = ai / 2;
      4'd12: r = ai * 2 + ai / 8;
      4'd13: r = ai / 2 + (ai % 2) * 8;
      default: r = 0;
    endcase
    return {c, r[3:0]};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge: drives inputs, advances the model, optionally pushes
  // the model's expectation, then returns at the next negedge.
  task automatic apply(input logic r, input logic v, input logic [3:0] ta,
                       input logic [3:0] tb, input logic tc, input logic [3:0] tctl,
                       input logic push_model);
    logic [4:0] mo;
    reset    = r;
    valid_in = v;
    a        = ta;
    b        = tb;
    cin      = tc;
    ctl      = tctl;
    if (r) begin
      m_valid = 1'b0; m_carry = 1'b0; m_zero = 1'b1; m_alu = 4'h0;
    end else begin
      m_valid = v;
      if (v) begin
        mo      = model_op(ta, tb, tc, tctl);
        m_carry = mo[4];
        m_alu   = mo[3:0];
        m_zero  = (mo[3:0] == 4'h0);
      end
    end
    if (push_model) exp_q.push_back({m_valid, m_carry, m_zero, m_alu});
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] e;
    logic [W-1:0] got;
    apply(1'b0, 1'b1, 4'h9, 4'h8, 1'b0, ADD, 1'b0);
    exp_q.push_back(7'b0_0_1_0000);
    apply(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, SEL, 1'b0);
    tests_run++; e = exp_q.pop_front(); got = {valid_out, carry, zero, alu};
    if (got !== e) begin tests_failed++; $display("FAIL reset: got %b exp %b", got, e); end
    // Reset must win over a simultaneous valid operation.
    exp_q.push_back(7'b0_0_1_0000);
    apply(1'b1, 1'b1, 4'hF, 4'h1, 1'b0, ADD, 1'b0);
    tests_run++; e = exp_q.pop_front(); got = {valid_out, carry, zero, alu};
    if (got !== e) begin tests_failed++; $display("FAIL reset_wins: got %b exp %b", got, e); end
  endtask

  task automatic test_arith();
    logic [W-1:0] e;
    logic [W-1:0] got;
    logic [3:0]   va [6]   = '{4'h9, 4'h7, 4'h3, 4'h5, 4'h1, 4'h0};
    logic [3:0]   vb [6]   = '{4'h8, 4'h8, 4'h3, 4'h2, 4'h2, 4'h0};
    logic         vc [6]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]   vop [6]  = '{ADD, ADD_c, SUB_b, SUB, ADD, DEC};
    logic [W-1:0] vexp [6] = '{7'b1_1_0_0001, 7'b1_1_1_0000, 7'b1_1_0_1111,
                               7'b1_0_0_0011, 7'b1_0_0_0011, 7'b1_0_0_1111};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vexp[i]);
      apply(1'b0, 1'b1, va[i], vb[i], vc[i], vop[i], 1'b0);
      tests_run++; e = exp_q.pop_front(); got = {valid_out, carry, zero, alu};
      if (got !== e) begin
        tests_failed++; $display("FAIL arith[%0d] ctl=%0d: got %b exp %b", i, vop[i], got, e);
      end
    end
  endtask

  // Back-to-back shifts/rotates plus illegal opcodes; each result checked
  // the cycle after it is issued while the next op is already being driven.
  task automatic test_back_to_back();
    logic [W-1:0] e;
    logic [W-1:0] got;
    logic [3:0]   vop [6]  = '{ROTATE_L, ROTATE_R, SHIFT_L, SHIFT_R, 4'd14, 4'd15};
    logic [W-1:0] vexp [6] = '{7'b1_0_0_0011, 7'b1_0_0_1100, 7'b1_0_0_0010,
                               7'b1_0_0_0100, 7'b1_0_1_0000, 7'b1_0_1_0000};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vexp[i]);
      apply(1'b0, 1'b1, 4'b1001, (i >= 4) ? 4'hF : 4'h6, 1'b1, vop[i], 1'b0);
      tests_run++; e = exp_q.pop_front(); got = {valid_out, carry, zero, alu};
      if (got !== e) begin
        tests_failed++; $display("FAIL b2b[%0d] ctl=%0d: got %b exp %b", i, vop[i], got, e);
      end
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] e;
    logic [W-1:0] got;
    exp_q.push_back(7'b1_0_1_0000);
    apply(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, INC, 1'b0);
    tests_run++; e = exp_q.pop_front(); got = {valid_out, carry, zero, alu};
    if (got !== e) begin tests_failed++; $display("FAIL inc_wrap: got %b exp %b", got, e); end
    exp_q.push_back(7'b0_0_1_0000);
    apply(1'b0, 1'b0, 4'h5, 4'h5, 1'b1, SEL, 1'b0);
    tests_run++; e = exp_q.pop_front(); got = {valid_out, carry, zero, alu};
    if (got !== e) begin tests_failed++; $display("FAIL hold_zero: got %b exp %b", got, e); end
    // Hold of a non-zero result with carry set across two idle cycles.
    exp_q.push_back(7'b1_1_0_1110);
    apply(1'b0, 1'b1, 4'hF, 4'hF, 1'b0, ADD, 1'b0);
    tests_run++; e = exp_q.pop_front(); got = {valid_out, carry, zero, alu};
    if (got !== e) begin tests_failed++; $display("FAIL add_ff: got %b exp %b", got, e); end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(7'b0_1_0_1110);
      apply(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, SEL, 1'b0);
      tests_run++; e = exp_q.pop_front(); got = {valid_out, carry, zero, alu};
      if (got !== e) begin tests_failed++; $display("FAIL hold_nz[%0d]: got %b exp %b", i, got, e); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    logic [W-1:0] got;
    logic         r;
    logic         v;
    // Re-align the model with the DUT through a reset first.
    apply(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, SEL, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 3) != 0);
      apply(r, v, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1);
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++; $display("FAIL rand[%0d]: queue empty", i);
      end else begin
        e = exp_q.pop_front(); got = {valid_out, carry, zero, alu};
        if (got !== e) begin
          tests_failed++;
          $display("FAIL rand[%0d] ctl=%0d a=%h b=%h cin=%b: got %b exp %b",
                   i, ctl, a, b, cin, got, e);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; valid_in = 1'b0; a = '0; b = '0; cin = 1'b0; ctl = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_arith();
    test_back_to_back();
    test_hold();
    test_random();
    if (exp_q.size() != 0) begin
      tests_run++; tests_failed++;
      $display("FAIL queue_drain: %0d left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_alu_unit
